// File: rtl/lsu_mem_master.sv
// lsu_mem_master
//   Load/store unit master for a byte-addressable 32-bit memory. A request is
//   accepted in IDLE, its fields are registered, one ISSUE cycle drives the
//   memory strobes, and the response is held in RESP until the core takes it.
//   Misaligned or illegal-size requests skip ISSUE and respond with an error.
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           request handshake
//   req_we, req_size, req_unsigned, req_addr, req_wdata   request fields
//   resp_valid/resp_ready         response handshake
//   resp_rdata, resp_err          extended load data, error flag
//   mem_gwe, mem_rd, mem_bw0..3   word write, read, byte-lane write strobes
//   mem_addr, mem_wdata           memory byte address and write data
//   mem_rdata                     memory word, valid at the edge ending ISSUE
module lsu_mem_master #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_we,
   input  logic [1:0]      req_size,
   input  logic            req_unsigned,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [XLEN-1:0] resp_rdata,
   output logic            resp_err,
   output logic            mem_gwe,
   output logic            mem_rd,
   output logic            mem_bw0,
   output logic            mem_bw1,
   output logic            mem_bw2,
   output logic            mem_bw3,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   input  logic [XLEN-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_RESP
   } state_t;

   state_t            state_q, state_d;
   logic              we_q, we_d;
   logic [1:0]        size_q, size_d;
   logic              uns_q, uns_d;
   logic [1:0]        off_q, off_d;
   logic              mem_gwe_q, mem_gwe_d;
   logic              mem_rd_q, mem_rd_d;
   logic [3:0]        mem_bw_q, mem_bw_d;
   logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
   logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
   logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
   logic              resp_err_q, resp_err_d;

   logic              req_legal;
   logic [XLEN-1:0]   lane_word;
   logic [XLEN-1:0]   load_ext;

   always_comb begin
      unique case (req_size)
         2'b00:   req_legal = 1'b1;
         2'b01:   req_legal = ~req_addr[0];
         2'b10:   req_legal = (req_addr[1:0] == 2'b00);
         default: req_legal = 1'b0;
      endcase
   end

   // Shift the addressed lane down to bit 0, then extend from its top bit.
   always_comb begin
      lane_word = mem_rdata >> {off_q, 3'b000};
      unique case (size_q)
         2'b00:   load_ext = {{(XLEN-8){~uns_q & lane_word[7]}}, lane_word[7:0]};
         2'b01:   load_ext = {{(XLEN-16){~uns_q & lane_word[15]}}, lane_word[15:0]};
         default: load_ext = mem_rdata;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      we_d         = we_q;
      size_d       = size_q;
      uns_d        = uns_q;
      off_d        = off_q;
      mem_gwe_d    = 1'b0;
      mem_rd_d     = 1'b0;
      mem_bw_d     = '0;
      mem_addr_d   = '0;
      mem_wdata_d  = '0;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
      unique case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               we_d         = req_we;
               size_d       = req_size;
               uns_d        = req_unsigned;
               off_d        = req_addr[1:0];
               resp_rdata_d = '0;
               if (req_legal) begin
                  state_d    = S_ISSUE;
                  resp_err_d = 1'b0;
                  mem_addr_d = req_addr;
                  if (req_we) begin
                     unique case (req_size)
                        2'b00: begin
                           mem_bw_d    = 4'b0001 << req_addr[1:0];
                           mem_wdata_d = {{(XLEN-8){1'b0}}, req_wdata[7:0]};
                        end
                        2'b01: begin
                           mem_bw_d    = 4'b0011 << req_addr[1:0];
                           mem_wdata_d = {{(XLEN-16){1'b0}}, req_wdata[15:0]};
                        end
                        default: begin
                           mem_gwe_d   = 1'b1;
                           mem_wdata_d = req_wdata;
                        end
                     endcase
                  end else begin
                     mem_rd_d = 1'b1;
                  end
               end else begin
                  state_d    = S_RESP;
                  resp_err_d = 1'b1;
               end
            end
         end
         S_ISSUE: begin
            state_d      = S_RESP;
            resp_rdata_d = we_q ? '0 : load_ext;
         end
         S_RESP: begin
            if (resp_ready) begin
               state_d      = S_IDLE;
               resp_rdata_d = '0;
               resp_err_d   = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         we_q         <= 1'b0;
         size_q       <= '0;
         uns_q        <= 1'b0;
         off_q        <= '0;
         mem_gwe_q    <= 1'b0;
         mem_rd_q     <= 1'b0;
         mem_bw_q     <= '0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         we_q         <= we_d;
         size_q       <= size_d;
         uns_q        <= uns_d;
         off_q        <= off_d;
         mem_gwe_q    <= mem_gwe_d;
         mem_rd_q     <= mem_rd_d;
         mem_bw_q     <= mem_bw_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

   assign req_ready  = (state_q == S_IDLE);
   assign resp_valid = (state_q == S_RESP);
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;
   assign mem_gwe    = mem_gwe_q;
   assign mem_rd     = mem_rd_q;
   assign mem_bw0    = mem_bw_q[0];
   assign mem_bw1    = mem_bw_q[1];
   assign mem_bw2    = mem_bw_q[2];
   assign mem_bw3    = mem_bw_q[3];
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;

endmodule

// File: doc/lsu_mem_master.md
LSU_MEM_MASTER -- requirements
Module: lsu_mem_master

Interface
REQ-001 Parameter: XLEN, 32, data/address width; only 32 supported (4 byte lanes, 2-bit byte offset).
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  1  core request present.
REQ-005 req_ready  output  1  request accepted when req_valid && req_ready at posedge.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-009 req_addr  input  XLEN  byte address.
REQ-010 req_wdata  input  XLEN  store data, right-justified.
REQ-011 resp_valid  output  1  response present; held until resp_ready.
REQ-012 resp_ready  input  1  core accepts response.
REQ-013 resp_rdata  output  XLEN  extended load data; 0 for stores and errors.
REQ-014 resp_err  output  1  misaligned or illegal-size request.
REQ-015 mem_gwe  output  1  word write enable to byte-addressable memory.
REQ-016 mem_rd  output  1  memory read strobe.
REQ-017 mem_bw0, mem_bw1, mem_bw2, mem_bw3  output  1 each  byte-lane write strobes.
REQ-018 mem_addr  output  XLEN  byte address to memory (upper bits word index, [1:0] byte offset).
REQ-019 mem_wdata  output  XLEN  write data to memory.
REQ-020 mem_rdata  input  XLEN  full word from memory; valid at first posedge after the cycle mem_rd was high (memory samples on negedge).

Function
REQ-021 FSM states: IDLE, ISSUE, RESP; req_ready = 1 only in IDLE.
REQ-022 IDLE: on accepted legal request -> ISSUE; on accepted illegal/misaligned request -> RESP with resp_err=1, no memory strobe ever asserted.
REQ-023 Legality: word needs addr[1:0]=00; half needs addr[0]=0; byte always legal; size 11 always illegal.
REQ-024 Request fields are registered at acceptance; later changes on req_* ignored until next IDLE.
REQ-025 ISSUE lasts exactly one cycle; all mem_* strobes registered, high only during ISSUE, 0 otherwise.
REQ-026 Word store: mem_gwe=1, all mem_bw*=0, mem_wdata=req_wdata.
REQ-027 Half store: mem_wdata={16'h0,wdata[15:0]}; offset 00 -> mem_bw0,mem_bw1; offset 10 -> mem_bw2,mem_bw3; mem_gwe=0.
REQ-028 Byte store: mem_wdata={24'h0,wdata[7:0]}; only mem_bw<offset>=1; mem_gwe=0.
REQ-029 Load: mem_rd=1, no write strobes; mem_addr=registered req_addr for all accesses.
REQ-030 ISSUE -> RESP at next posedge; load captures mem_rdata at that edge, selects byte lane offset (bits [8*off+7:8*off]) or half lane (off 00 -> [15:0], 10 -> [31:16]), word unmodified, then sign/zero extends per req_unsigned.
REQ-031 RESP: resp_valid=1, resp_rdata/resp_err stable; on resp_ready -> IDLE at that edge; earliest next acceptance one cycle later.
REQ-032 Latency: accept edge to resp_valid = 2 cycles legal, 1 cycle error; throughput one request per 3 cycles minimum.
REQ-033 resp_ready low holds RESP indefinitely with outputs unchanged; no memory activity while waiting.

Reset
REQ-034 rst high at posedge: state IDLE; req_ready=1 after reset; resp_valid, resp_err, resp_rdata, mem_gwe, mem_rd, mem_bw*, mem_addr, mem_wdata all 0.
REQ-035 rst takes priority over every transition; rst during ISSUE clears strobes at that edge and discards the pending response; rst during RESP drops resp_valid without handshake.
REQ-036 req_valid during rst is not accepted.

Verification
REQ-037 Word store 0xDEADBEEF @0x10, then word load @0x10 -> single ISSUE cycle with mem_gwe=1; load resp_rdata=0xDEADBEEF, resp_err=0, resp_valid 2 cycles after accept.
REQ-038 Byte store 0x80 @0x13, signed byte load @0x13 -> mem_bw3 only, mem_wdata=0x00000080; resp_rdata=0xFFFFFF80; unsigned load -> 0x00000080.
REQ-039 Half store 0x8001 @0x22, signed/unsigned half loads @0x22 -> mem_bw2,mem_bw3, mem_wdata=0x00008001; resp_rdata=0xFFFF8001 / 0x00008001.
REQ-040 Word load @0x06, half load @0x05, size=11 @0x00 -> resp_err=1, resp_rdata=0, response 1 cycle after accept, mem strobes never high.
REQ-041 Hold resp_ready=0 for 5 cycles -> resp_valid and resp_rdata stable, req_ready=0 throughout; IDLE one cycle after resp_ready.
REQ-042 Assert rst during ISSUE of a store -> all outputs 0 next cycle, no resp_valid, req_ready=1 after rst release.
